rng_word_arbiter: RTL
=====================

// Module: rng_word_arbiter
// PURPOSE
//  Sits downstream of the 2-bit entropy collector in the random number generator.
//  Applies von Neumann debiasing to each 2-bit symbol and packs the resulting bits into words.
//  Shares the generated words among NUM_REQ requesters with a round-robin req/grant handshake.
//  Raises a health alarm when the entropy source produces a long run of discarded symbols.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  WORD_W     32  bits per delivered random word (>=2)
//  ALARM_RUN  64  consecutive discarded symbols that trip stall_alarm (>=1)
// PORTS
//  clk          in   1        single clock; all logic is rising-edge
//  reset_n      in   1        asynchronous, active-low reset
//  enable       in   1        1 = accept symbols; 0 = clear packer and alarm, hold buffered word
//  snk_data     in   2        collector symbol; bit1 = older raw bit, bit0 = newer raw bit
//  snk_valid    in   1        symbol strobe (no backpressure: the source cannot be stalled)
//  req          in   NUM_REQ  per-requester request level; held until that requester's grant
//  grant        out  NUM_REQ  one-hot, one-cycle grant pulse
//  rnd_data     out  WORD_W   delivered word; meaningful only while rnd_valid=1
//  rnd_valid    out  1        high in the same cycle as any grant bit
//  stall_alarm  out  1        sticky entropy-health alarm
// BEHAVIOUR
//  Reset:
//   - grant=0, rnd_valid=0, rnd_data=0, stall_alarm=0.
//   - Packer count=0, holding register empty, discard-run counter=0, RR pointer=NUM_REQ-1.
//   - Any partial word is lost.
//  Debias (edge with snk_valid & enable):
//   - Symbol 2'b10 -> bit 1; 2'b01 -> bit 0.
//   - Symbols 2'b00/2'b11 are discarded.
//  Packer:
//   - shreg <= {shreg[WORD_W-2:0], bit}; count increments. The first bit ends up at the MSB.
//   - At count==WORD_W the packer is full. On any edge with the holding register empty, the word moves into holding and count returns to 0.
//   - Holding full and packer full: accepted bits are dropped; they do not affect the alarm counter.
//  Arbitration (registered):
//   - At an edge with holding valid and |req, exactly one grant bit is set for the next cycle.
//   - The granted requester is the first requester with req=1 searching upward from RR pointer+1, mod NUM_REQ.
//   - rnd_valid=1 and rnd_data=holding word in that same cycle.
//   - Holding clears and the pointer updates to the granted index.
//   - The refill from a full packer occurs on the following edge, so a word can be served at most every 2nd cycle.
//   - req=0 on all inputs: no grant; the word is retained indefinitely.
//   - rnd_data holds its last value when rnd_valid=0.
//  Alarm:
//   - The run counter increments on each discarded symbol and saturates at ALARM_RUN.
//   - It clears on each accepted symbol (10/01).
//   - stall_alarm sets on the edge where the count reaches ALARM_RUN.
//   - stall_alarm stays set until enable=0 or reset.
//  enable=0:
//   - Symbols are ignored; packer count and run counter are cleared; stall_alarm clears.
//   - The holding word is kept and still served through arbitration.
//  Simultaneous events:
//   - A grant and a packer-complete in the same edge: the grant is served first; holding reloads on the next edge.
//   - snk_valid together with enable falling (enable=0 at the edge): the symbol is ignored.
// TESTING
//  1. Reset, enable=1, req=4'b0001, 32 symbols alternating 10,01
//     -> grant=4'b0001 for 1 cycle, rnd_valid=1, rnd_data=32'hAAAA_AAAA.
//  2. Same 32 symbols as test 1, with 00/11 interleaved between them
//     -> identical word 32'hAAAA_AAAA; stall_alarm stays 0.
//  3. req=4'b1111 held, 5 words generated
//     -> grant sequence 0001,0010,0100,1000,0001; never two bits set at once.
//  4. 64 consecutive 2'b11 symbols
//     -> stall_alarm=1 after the 64th symbol edge; a following 10 symbol keeps it at 1; enable=0 for one cycle clears it.
//  5. req=0 while 3 words' worth of accepted bits arrive (word A, word B, 32 extra bits)
//     -> then req=4'b0100 yields grants delivering A then B; the extra bits are absent from both.
//  6. reset_n low after 10 accepted bits of a word
//     -> outputs 0 immediately; after release a full 32 fresh bits are needed before any grant.

Source files
------------

// File: rtl/rng_word_arbiter.sv
// rng_word_arbiter: von Neumann debiaser, word packer and round-robin word server with entropy stall alarm.
module rng_word_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_W    = 32,
  parameter int ALARM_RUN = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         snk_data,
  input  logic               snk_valid,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [WORD_W-1:0]  rnd_data,
  output logic               rnd_valid,
  output logic               stall_alarm
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(WORD_W + 1);
  localparam int RW = $clog2(ALARM_RUN + 1);
  logic [WORD_W-1:0] shreg, hold;
  logic [CW-1:0]     count;
  logic [RW-1:0]     run;
  logic [PW-1:0]     ptr, sel;
  logic              hold_v, found, acc, dis, full, move, take;
  int                j;
  assign acc  = snk_valid & enable & (snk_data[1] ^ snk_data[0]);
  assign dis  = snk_valid & enable & ~(snk_data[1] ^ snk_data[0]);
  assign full = count == CW'(WORD_W);
  assign move = enable & full & ~hold_v;
  // bits arriving while both packer and holding are full are dropped
  assign take = acc & (~full | move);
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    j     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (req[j]) begin
        found = 1'b1;
        sel   = PW'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= '0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
      stall_alarm <= 1'b0;
      shreg       <= '0;
      hold        <= '0;
      hold_v      <= 1'b0;
      count       <= '0;
      run         <= '0;
      ptr         <= PW'(NUM_REQ - 1);
    end else begin
      grant     <= '0;
      rnd_valid <= 1'b0;
      if (hold_v && found) begin
        grant     <= NUM_REQ'(1) << sel;
        rnd_valid <= 1'b1;
        rnd_data  <= hold;
        hold_v    <= 1'b0;
        ptr       <= sel;
      end else if (move) begin
        hold   <= shreg;
        hold_v <= 1'b1;
      end
      if (!enable) begin
        count       <= '0;
        run         <= '0;
        stall_alarm <= 1'b0;
      end else begin
        if (take) begin
          shreg <= {shreg[WORD_W-2:0], snk_data[1]};
          count <= move ? CW'(1) : count + CW'(1);
        end else if (move) begin
          count <= '0;
        end
        if (dis) run <= (run == RW'(ALARM_RUN)) ? run : run + RW'(1);
        else if (take) run <= '0;
        if (dis && run >= RW'(ALARM_RUN - 1)) stall_alarm <= 1'b1;
      end
    end
  end
endmodule
